// File: rtl/bcd_cnt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_cnt_ctrl
//  Purpose  : Run/pause/clear sequencer for a 4-digit cascaded BCD counter
//             with prescaled count tick, wrap carry-out and terminal stop.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_cnt_ctrl #(
    parameter int CLK_DIV = 50_000,
    parameter int DIV_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [15:0] target,
    output logic [15:0] cnt_out,
    output logic        tick,
    output logic        cout,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [15:0]      cnt_inc;
    logic [4:0]       carry;
    logic             tick_w;
    logic             match_w;

    // Ripple carry: digit k advances only when every lower digit is 9.
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < 4; k++) begin : g_digit
        logic [3:0] dig;
        assign dig            = cnt_q[4*k +: 4];
        assign carry[k+1]     = carry[k] && (dig == 4'd9);
        assign cnt_inc[4*k +: 4] = !carry[k]      ? dig  :
                                   (dig == 4'd9)  ? 4'd0 :
                                                    dig + 4'd1;
    end

    assign tick_w  = (state_q == S_RUN) && (div_q == DIV_LAST);
    // A nibble above 9 in target can never equal a legal BCD count.
    assign match_w = (target != 16'h0000) && (cnt_inc == target);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        cout_d  = 1'b0;
        done_d  = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            div_d   = '0;
            cnt_d   = 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (tick_w) begin
                        div_d  = '0;
                        cnt_d  = cnt_inc;
                        cout_d = carry[4];
                    end else begin
                        div_d  = div_q + DIV_W'(1);
                    end
                    if (tick_w && match_w) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (stop) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) state_d = S_RUN;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= 16'h0000;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign cnt_out = cnt_q;
    assign tick    = tick_w;
    assign cout    = cout_q;
    assign done    = done_q;
    assign busy    = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_bcd_cnt_ctrl.sv
`default_nettype none
// Directed bench for bcd_cnt_ctrl: one prescaled instance (CLK_DIV=4) and one
// undivided instance (CLK_DIV=1), sharing clock and reset.
module tb_bcd_cnt_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start4, stop4, clear4;
    logic [15:0] target4;
    logic [15:0] cnt4;
    logic        tick4, cout4, done4, busy4;
    logic        start1, stop1, clear1;
    logic [15:0] target1;
    logic [15:0] cnt1;
    logic        tick1, cout1, done1, busy1;

    int checks;
    int errors;

    bcd_cnt_ctrl #(.CLK_DIV(4), .DIV_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .clear(clear4),
        .target(target4), .cnt_out(cnt4), .tick(tick4), .cout(cout4),
        .done(done4), .busy(busy4)
    );

    bcd_cnt_ctrl #(.CLK_DIV(1), .DIV_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .clear(clear1),
        .target(target1), .cnt_out(cnt1), .tick(tick1), .cout(cout1),
        .done(done1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(2);
        checks++;
        if ({cnt4, tick4, cout4, done4, busy4} !== 20'h0) begin
            errors++;
            $display("FAIL reset_u4 got %h want 00000", {cnt4, tick4, cout4, done4, busy4});
        end
        checks++;
        if ({cnt1, tick1, cout1, done1, busy1} !== 20'h0) begin
            errors++;
            $display("FAIL reset_u1 got %h want 00000", {cnt1, tick1, cout1, done1, busy1});
        end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_idle;
        target4 = 16'h0000;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) stop4 = 1'b1;
            if (i == 21) stop4 = 1'b0;
            checks++;
            if (cnt4 !== 16'h0000 || busy4 !== 1'b0 || tick4 !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc %0d got cnt=%h busy=%b tick=%b want 0000 0 0", i, cnt4, busy4, tick4);
            end
            cyc(1);
        end
    endtask

    task automatic test_terminal;
        target4 = 16'h0012;
        start4 = 1'b1;
        cyc(1);
        start4 = 1'b0;
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (tick4 !== (i % 4 == 3) || cnt4 !== to_bcd(i / 4) || busy4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL term cyc %0d got tick=%b cnt=%h busy=%b done=%b want tick=%b cnt=%h busy=1 done=0",
                         i, tick4, cnt4, busy4, done4, (i % 4 == 3), to_bcd(i / 4));
            end
            cyc(1);
        end
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 16'h0012 || tick4 !== 1'b0) begin
            errors++;
            $display("FAIL term_done got done=%b busy=%b cnt=%h tick=%b want 1 0 0012 0", done4, busy4, cnt4, tick4);
        end
        start4 = 1'b1;
        cyc(1);
        start4 = 1'b0;
        checks++;
        if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL term_done_width got done=%b want 0", done4);
        end
        cyc(8);
        checks++;
        if (busy4 !== 1'b0 || cnt4 !== 16'h0012 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL term_hold got busy=%b cnt=%h done=%b want 0 0012 0", busy4, cnt4, done4);
        end
        clear4 = 1'b1;
        cyc(1);
        clear4 = 1'b0;
        checks++;
        if (cnt4 !== 16'h0000 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL term_clear got cnt=%h busy=%b want 0000 0", cnt4, busy4);
        end
    endtask

    task automatic test_pause_resume;
        bit found;
        target4 = 16'h0000;
        start4 = 1'b1;
        cyc(1);
        start4 = 1'b0;
        cyc(12);
        checks++;
        if (cnt4 !== 16'h0003) begin
            errors++;
            $display("FAIL pause_pre got cnt=%h want 0003", cnt4);
        end
        cyc(1);
        stop4 = 1'b1;
        cyc(1);
        stop4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (cnt4 !== 16'h0003 || busy4 !== 1'b0 || tick4 !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold cyc %0d got cnt=%h busy=%b tick=%b want 0003 0 0", i, cnt4, busy4, tick4);
            end
            cyc(1);
        end
        start4 = 1'b1;
        cyc(1);
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || tick4 !== 1'b0) begin
            errors++;
            $display("FAIL resume_0 got busy=%b tick=%b want 1 0", busy4, tick4);
        end
        cyc(1);
        checks++;
        if (tick4 !== 1'b1 || cnt4 !== 16'h0003) begin
            errors++;
            $display("FAIL resume_tick got tick=%b cnt=%h want 1 0003", tick4, cnt4);
        end
        cyc(1);
        checks++;
        if (cnt4 !== 16'h0004 || tick4 !== 1'b0) begin
            errors++;
            $display("FAIL resume_step got cnt=%h tick=%b want 0004 0", cnt4, tick4);
        end
        // stop landing on the tick edge at 0007
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cnt4 === 16'h0007 && tick4 === 1'b1) found = 1'b1;
            else cyc(1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_tick7 got timeout want tick at 0007");
        end
        stop4 = 1'b1;
        cyc(1);
        stop4 = 1'b0;
        checks++;
        if (cnt4 !== 16'h0008 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL stop_on_tick got cnt=%h busy=%b want 0008 0", cnt4, busy4);
        end
        start4 = 1'b1;
        stop4  = 1'b1;
        cyc(1);
        start4 = 1'b0;
        stop4  = 1'b0;
        cyc(5);
        checks++;
        if (busy4 !== 1'b0 || cnt4 !== 16'h0008) begin
            errors++;
            $display("FAIL start_stop_pause got busy=%b cnt=%h want 0 0008", busy4, cnt4);
        end
        clear4 = 1'b1;
        cyc(1);
        clear4 = 1'b0;
    endtask

    task automatic test_clear_on_tick;
        bit found;
        start4 = 1'b1;
        cyc(1);
        start4 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cnt4 === 16'h0005 && tick4 === 1'b1) found = 1'b1;
            else cyc(1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_tick5 got timeout want tick at 0005");
        end
        clear4 = 1'b1;
        cyc(1);
        clear4 = 1'b0;
        checks++;
        if (cnt4 !== 16'h0000 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL clear_on_tick got cnt=%h busy=%b want 0000 0", cnt4, busy4);
        end
        cyc(10);
        checks++;
        if (cnt4 !== 16'h0000 || busy4 !== 1'b0 || tick4 !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle got cnt=%h busy=%b tick=%b want 0000 0 0", cnt4, busy4, tick4);
        end
    endtask

    // Runs u1 for 10005 samples with the given target and checks the full
    // count sequence, digit legality, the single cout and absence of done.
    task automatic run_free(input logic [15:0] tgt, input string tag);
        int couts;
        target1 = tgt;
        clear1 = 1'b1;
        cyc(1);
        clear1 = 1'b0;
        start1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        couts = 0;
        for (int i = 0; i <= 10004; i++) begin
            checks++;
            if (cnt1 !== to_bcd(i % 10000) || done1 !== 1'b0 || cout1 !== (i == 10000)) begin
                errors++;
                $display("FAIL %s cyc %0d got cnt=%h cout=%b done=%b want cnt=%h cout=%b done=0",
                         tag, i, cnt1, cout1, done1, to_bcd(i % 10000), (i == 10000));
            end
            if (i == 100) begin
                checks++;
                if (cnt1 !== 16'h0100) begin
                    errors++;
                    $display("FAIL %s_0100 got %h want 0100", tag, cnt1);
                end
            end
            if (i == 1000) begin
                checks++;
                if (cnt1 !== 16'h1000) begin
                    errors++;
                    $display("FAIL %s_1000 got %h want 1000", tag, cnt1);
                end
            end
            if (cout1 === 1'b1) couts++;
            cyc(1);
        end
        checks++;
        if (couts != 1) begin
            errors++;
            $display("FAIL %s_cout_count got %0d want 1", tag, couts);
        end
    endtask

    task automatic test_async_reset;
        target1 = 16'h0000;
        clear1 = 1'b1;
        cyc(1);
        clear1 = 1'b0;
        start1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        cyc(50);
        checks++;
        if (cnt1 !== 16'h0050 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got cnt=%h busy=%b want 0050 1", cnt1, busy1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt1, tick1, cout1, done1, busy1} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset got %h want 00000", {cnt1, tick1, cout1, done1, busy1});
        end
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            checks++;
            if (cout1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 16'h0000) begin
                errors++;
                $display("FAIL post_reset cyc %0d got cnt=%h cout=%b done=%b busy=%b want 0000 0 0 0",
                         i, cnt1, cout1, done1, busy1);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start4  = 1'b0; stop4 = 1'b0; clear4 = 1'b0; target4 = 16'h0000;
        start1  = 1'b0; stop1 = 1'b0; clear1 = 1'b0; target1 = 16'h0000;
        test_reset;
        test_idle;
        test_terminal;
        test_pause_resume;
        test_clear_on_tick;
        run_free(16'h0000, "wrap");
        run_free(16'h00A0, "badtgt");
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_cnt_ctrl.md
Name: bcd_cnt_ctrl

Overview:
Run/pause/clear controller for a 4-digit cascaded decade (BCD) counter chain.
- Generates the prescaled count-enable tick.
- Sequences digit-to-digit carries.
- Stops at a programmable BCD terminal value, or wraps freely.
- Sits between the front-panel key logic (debounced single-cycle pulses) and the 7-segment display driver. It is the sequencing block for the decade-counter datapath.

Parameters:
CLK_DIV, 50_000, clk cycles per count tick (>=1); 50_000 gives 1 kHz at 50 MHz
DIV_W, 16, width of prescaler counter; must satisfy 2**DIV_W >= CLK_DIV

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  single-cycle pulse: begin/resume counting
stop  input  1  single-cycle pulse: pause counting
clear  input  1  single-cycle pulse: zero count, return to IDLE
target  input  16  BCD terminal value, 4 digits [15:12]..[3:0]; 16'h0000 = free run
cnt_out  output  16  current BCD count, digit0 = [3:0]
tick  output  1  high for the one cycle in which the count advances
cout  output  1  one-cycle pulse on the 9999->0000 wrap
done  output  1  one-cycle pulse on entry to DONE
busy  output  1  high while state == RUN

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; prescaler = 0; cnt_out = 16'h0000.
  - tick, cout, done, busy = 0.
- States and transitions (all on the clock edge): IDLE, RUN, PAUSE, DONE.
  - Priority: clear > stop > start.
  - clear in any state: go to IDLE; cnt_out = 0 and prescaler = 0 on the same edge.
  - IDLE: start -> RUN; stop is ignored.
  - RUN: stop -> PAUSE; start is ignored; reaching target -> DONE.
  - PAUSE: start -> RUN. Prescaler and count hold, so the partial tick period resumes rather than restarting. start and stop together -> stay in PAUSE.
  - DONE: start and stop are ignored; only clear or reset leaves this state.
- Prescaler:
  - Increments only in RUN.
  - tick = (state == RUN) && (prescaler == CLK_DIV-1). tick is combinational from registers.
  - On tick, prescaler wraps to 0. CLK_DIV = 1 gives tick every RUN cycle.
  - First tick occurs CLK_DIV cycles after the edge that enters RUN from IDLE.
- Count update on the tick edge:
  - digit0 increments.
  - Digit k increments only if digits 0..k-1 are all 9.
  - Any digit at 9 that increments becomes 0.
  - Digits never hold a value >9.
- Wrap: at 9999 with target == 0, the next tick gives 0000, and cout is high for the cycle following that edge (registered). Counting continues.
- Terminal compare:
  - Applies when target != 0 and the post-increment count == target.
  - On that edge: state -> DONE; done is high for the next cycle; count holds at target.
- Invalid or unreachable targets:
  - A target with any nibble >9 never matches, so the counter behaves as free run, including wrap and cout.
  - target is sampled every cycle. Changing it mid-run takes effect at the next tick. If the new target is below the current count, the match occurs after the wrap.
- Simultaneous events on the tick edge:
  - stop: the increment is still applied; the state goes to PAUSE.
  - clear: clear wins; the count is 0 and no increment is applied.
  - Terminal match and stop together: DONE wins over PAUSE.
  - Wrap and terminal cannot coincide, because target 0000 means free run.
- busy = (state == RUN), registered state decode.
- Reset asserted mid-count: all state is lost immediately (asynchronous). No pulse outputs fire on reset release.

Test Plan:
- Reset then idle, CLK_DIV=4, target=0: no start for 50 cycles -> cnt_out=0000, busy=0, tick never high; stop pulse ignored.
- start with CLK_DIV=4, target=0012:
  - tick every 4th cycle; cnt_out steps 0000..0009, 0010, 0011, 0012.
  - done pulses once on the cycle after the 12th tick; busy drops; count holds; a further start is ignored.
- Pause/resume: start, stop 2 cycles after the 3rd tick, wait 20 cycles, then start.
  - cnt_out holds 0003 during the pause.
  - Next tick arrives 2 cycles after resume (prescaler preserved).
- Free-run wrap, CLK_DIV=1, target=0:
  - Run 10000 cycles; cnt_out passes 0099->0100 and 0999->1000.
  - At 9999->0000, cout is high exactly one cycle.
  - No nibble ever exceeds 9.
- Priority and collisions:
  - clear coincident with tick at count 0005 -> 0000, IDLE.
  - start+stop in PAUSE -> stays in PAUSE.
  - stop on the tick edge at 0007 -> 0008, PAUSE.
- Invalid target 00A0 with CLK_DIV=1 -> never done; wraps with a cout pulse. Asserting rst_n low mid-count clears all outputs without waiting for a clock edge.
